// File: rtl/event_pkg.sv
// event_pkg: shared event encoding constants, polarity codes and the event packer
// for the DVS event encoder and its FIFO.
package event_pkg;
    localparam int EVT_W = 8;
    localparam int NPIX  = 16;
    localparam int X_OFF = 0;
    localparam int Y_OFF = 2;
    localparam int T_OFF = 4;
    localparam int P_OFF = 6;

    typedef enum logic [1:0] {
        POL_NONE = 2'b00,
        POL_OFF  = 2'b10,
        POL_ON   = 2'b11
    } pol_e;

    function automatic logic [EVT_W-1:0] pack_evt(pol_e p, logic [1:0] t, logic [3:0] a);
        logic [EVT_W-1:0] e;
        e = '0;
        e[P_OFF +: 2] = p;
        e[T_OFF +: 2] = t;
        e[Y_OFF +: 2] = a[3:2];
        e[X_OFF +: 2] = a[1:0];
        return e;
    endfunction
endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous FIFO; head output comes only from flops and reads 0 when empty.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full  = cnt_q == CNT_MAX;
    assign empty = cnt_q == '0;
    assign dout  = empty ? '0 : mem_q[rd_q];

    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/dvs_event_encoder.sv
// dvs_event_encoder: turns a 4x4 raster of pixel samples into ON/OFF events against a
// per-pixel reference level and queues them in a small FIFO for the downstream filter.
module dvs_event_encoder
    import event_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PIX_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic [3:0]       addr_q, addr_d;
    logic [1:0]       frame_q, frame_d;
    logic [PIX_W-1:0] ref_q [NPIX];
    logic [PIX_W-1:0] ref_d [NPIX];
    logic [NPIX-1:0]  rv_q, rv_d;
    logic             tick_q, tick_d, ovf_q, ovf_d;
    logic             accept, pop, push, evt, full, empty, last_pix;
    logic [PIX_W-1:0] s;
    logic [PIX_W:0]   s_x, r_x, thr_x;
    logic [EVT_W-1:0] evt_data;
    pol_e             pol;
    logic             unused_ok;

    assign s         = ui_in[PIX_W-1:0];
    assign unused_ok = &{1'b0, ui_in[7:5], uio_in[3:1]};

    always_comb begin
        accept   = ena & ui_in[4];
        last_pix = accept & (addr_q == 4'hF);
        s_x      = {1'b0, s};
        r_x      = {1'b0, ref_q[addr_q]};
        thr_x    = (PIX_W+1)'((uio_in[7:4] == 4'd0) ? 4'd1 : uio_in[7:4]);
        pol      = POL_NONE;
        if (accept && rv_q[addr_q])
            pol = (s_x >= r_x + thr_x) ? POL_ON : ((s_x + thr_x <= r_x) ? POL_OFF : POL_NONE);
        evt      = pol != POL_NONE;
        pop      = ena & uio_in[0] & ~empty;
        // A dropped event leaves the reference alone so the change is reported again next frame.
        push     = evt & (~full | pop);
        ovf_d    = ovf_q | (evt & ~push);
        rv_d     = rv_q;
        ref_d    = ref_q;
        if (accept && !rv_q[addr_q]) begin
            rv_d[addr_q]  = 1'b1;
            ref_d[addr_q] = s;
        end
        if (push) ref_d[addr_q] = s;
        addr_d   = accept ? addr_q + 4'd1 : addr_q;
        frame_d  = last_pix ? frame_q + 2'd1 : frame_q;
        tick_d   = ena ? last_pix : tick_q;
        evt_data = pack_evt(pol, frame_q, addr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIX; i++) ref_q[i] <= '0;
            addr_q  <= '0;
            frame_q <= '0;
            rv_q    <= '0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ref_q   <= ref_d;
            addr_q  <= addr_d;
            frame_q <= frame_d;
            rv_q    <= rv_d;
            tick_q  <= tick_d;
            ovf_q   <= ovf_d;
        end
    end

    event_fifo #(.DEPTH(FIFO_DEPTH), .W(EVT_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (evt_data),
        .dout  (uo_out),
        .full  (full),
        .empty (empty)
    );

    assign uio_out = {4'b0, tick_q, ovf_q, full, 1'b0};
    assign uio_oe  = 8'b0000_1110;
endmodule

// File: tb/tb_dvs_event_encoder.sv
// tb_dvs_event_encoder: scoreboard bench; a reference model queues expected events as
// samples are driven and every cycle the FIFO head and flags are compared against it.
module tb_dvs_event_encoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         ref_m[16];
    bit         rv_m[16];
    int         addr_m, frame_m, thr_cfg;
    bit         ovf_m, tick_m;

    always #5 clk = ~clk;

    dvs_event_encoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            rv_m[i]  = 1'b0;
            ref_m[i] = 0;
        end
        addr_m  = 0;
        frame_m = 0;
        ovf_m   = 1'b0;
        tick_m  = 1'b0;
    endtask

    // Called at a negedge: drive one cycle, check head/flags, advance model, end at next negedge.
    task automatic step(input bit valid, input int s, input bit ready);
        int         thr, p;
        bit         pop_m;
        logic [7:0] head, flags;
        ui_in  = {3'b000, valid, 4'(s)};
        uio_in = {4'(thr_cfg), 3'b000, ready};
        #1;
        head  = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
        flags = {4'b0, tick_m, ovf_m, exp_q.size() == 4, 1'b0};
        n_checks++;
        if (uo_out !== head) begin
            n_fail++;
            $display("FAIL sb_head: uo_out=%h expected %h", uo_out, head);
        end
        n_checks++;
        if (uio_out !== flags) begin
            n_fail++;
            $display("FAIL sb_flags: uio_out=%b expected %b", uio_out, flags);
        end
        thr   = (thr_cfg == 0) ? 1 : thr_cfg;
        pop_m = ready && exp_q.size() > 0;
        p     = 0;
        if (valid) begin
            if (!rv_m[addr_m]) begin
                rv_m[addr_m]  = 1'b1;
                ref_m[addr_m] = s;
            end else if (s >= ref_m[addr_m] + thr) p = 3;
            else if (s + thr <= ref_m[addr_m]) p = 2;
        end
        if (pop_m) void'(exp_q.pop_front());
        if (p != 0) begin
            if (exp_q.size() < 4) begin
                exp_q.push_back(8'(p * 64 + frame_m * 16 + addr_m));
                ref_m[addr_m] = s;
            end else ovf_m = 1'b1;
        end
        tick_m = valid && addr_m == 15;
        if (valid) begin
            if (addr_m == 15) frame_m = (frame_m + 1) % 4;
            addr_m = (addr_m + 1) % 16;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo: uo_out=%h expected 00", uo_out); end
        n_checks++;
        if (uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio: uio_out=%h expected 00", uio_out); end
        n_checks++;
        if (uio_oe !== 8'h0E) begin n_fail++; $display("FAIL reset_oe: uio_oe=%h expected 0e", uio_oe); end
    endtask

    task automatic test_flat_frame();
        thr_cfg = 2;
        for (int i = 0; i < 16; i++) step(1'b1, 5, 1'b1);
        n_checks++;
        if (uio_out[3] !== 1'b1) begin n_fail++; $display("FAIL flat_tick: frame_tick=%b expected 1", uio_out[3]); end
        n_checks++;
        if (uo_out !== 8'h00) begin n_fail++; $display("FAIL flat_uo: uo_out=%h expected 00", uo_out); end
        step(1'b0, 0, 1'b1);
        n_checks++;
        if (uio_out[3] !== 1'b0) begin n_fail++; $display("FAIL flat_tick_end: frame_tick=%b expected 0", uio_out[3]); end
    endtask

    task automatic test_on_event();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i == 6) ? 9 : 5, 1'b1);
            if (i == 6) begin
                n_checks++;
                if (uo_out !== 8'hD6) begin n_fail++; $display("FAIL on_evt: uo_out=%h expected d6", uo_out); end
            end
        end
    endtask

    task automatic test_off_event();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i == 6 || i == 7) ? 6 : 5, 1'b1);
            if (i == 6) begin
                n_checks++;
                if (uo_out !== 8'hA6) begin n_fail++; $display("FAIL off_evt: uo_out=%h expected a6", uo_out); end
            end
            if (i == 7) begin
                n_checks++;
                if (uo_out !== 8'h00) begin n_fail++; $display("FAIL below_thr: uo_out=%h expected 00", uo_out); end
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) step(1'b1, (i < 5) ? 15 : ((i == 6) ? 6 : 5), 1'b0);
        n_checks++;
        if (uio_out[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_full: fifo_full=%b expected 1", uio_out[1]); end
        n_checks++;
        if (uio_out[2] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: overflow=%b expected 1", uio_out[2]); end
        repeat (4) step(1'b0, 0, 1'b1);
        n_checks++;
        if (uo_out !== 8'h00) begin n_fail++; $display("FAIL ovf_drain: uo_out=%h expected 00", uo_out); end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i < 5) ? 15 : ((i == 6) ? 6 : 5), 1'b1);
            if (i == 4) begin
                n_checks++;
                if (uo_out !== 8'hC4) begin n_fail++; $display("FAIL ovf_rereport: uo_out=%h expected c4", uo_out); end
            end
        end
    endtask

    task automatic test_full_pop_push();
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 5, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i < 5) ? 9 : 5, i >= 4);
            if (i == 4) begin
                n_checks++;
                if (uio_out[2:1] !== 2'b01) begin n_fail++; $display("FAIL fpp_flags: ovf,full=%b expected 01", uio_out[2:1]); end
                n_checks++;
                if (uo_out !== 8'hD1) begin n_fail++; $display("FAIL fpp_head: uo_out=%h expected d1", uo_out); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) step(1'b1, (i < 4) ? 13 : ((i == 4) ? 9 : 5), 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (uo_out !== 8'h00) begin n_fail++; $display("FAIL rmid_uo: uo_out=%h expected 00", uo_out); end
        n_checks++;
        if (uio_out !== 8'h00) begin n_fail++; $display("FAIL rmid_uio: uio_out=%h expected 00", uio_out); end
        do_reset();
        thr_cfg = 0;
        for (int i = 0; i < 16; i++) step(1'b1, i, 1'b1);
        n_checks++;
        if (uo_out !== 8'h00) begin n_fail++; $display("FAIL rmid_first_frame: uo_out=%h expected 00", uo_out); end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i == 3) ? 4 : i, 1'b1);
            if (i == 3) begin
                n_checks++;
                if (uo_out !== 8'hD3) begin n_fail++; $display("FAIL thr_zero: uo_out=%h expected d3", uo_out); end
            end
        end
        step(1'b0, 0, 1'b1);
    endtask

    initial begin
        thr_cfg = 2;
        model_reset();
        @(negedge clk);
        test_reset();
        test_flat_frame();
        test_on_event();
        test_off_event();
        test_overflow();
        test_full_pop_push();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
